// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes. Single-cycle ops respond one cycle after acceptance, and the response holds until resp_ready.
// MUL is shift-add (WIDTH+1 cycles) unless ALU_SEQ_FAST_MUL_EN selects a one-cycle combinational multiply.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_err,
    output logic             busy
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_LSH = 4'b0011;
    localparam logic [3:0] OP_RSH = 4'b0100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_req_ready;
    logic             r_busy;
    logic             r_resp_valid;
    logic [WIDTH-1:0] r_resp_result;
    logic             r_resp_err;

    logic [WIDTH-1:0] w_quick_result;
    logic             w_quick_err;
    logic             w_shift_oob;

`ifndef ALU_SEQ_FAST_MUL_EN
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_is_mul;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_is_mul   = (req_op == OP_MUL);
`endif

    // Single-cycle results are computed straight from the request at the accept edge.
    always_comb begin
        w_shift_oob    = (req_b >= WIDTH'(WIDTH));
        w_quick_result = '0;
        w_quick_err    = 1'b0;
        case (req_op)
            OP_ADD: w_quick_result = req_a + req_b;
            OP_SUB: w_quick_result = req_a - req_b;
            OP_LSH: w_quick_result = w_shift_oob ? '0 : (req_a << req_b);
            OP_RSH: w_quick_result = w_shift_oob ? '0 : (req_a >> req_b);
            OP_MUL: begin
`ifdef ALU_SEQ_FAST_MUL_EN
                w_quick_result = req_a * req_b;
`endif
            end
            default: w_quick_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_req_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_result <= '0;
            r_resp_err    <= 1'b0;
`ifndef ALU_SEQ_FAST_MUL_EN
            r_mcand       <= '0;
            r_mplier      <= '0;
            r_acc         <= '0;
            r_cnt         <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
`ifndef ALU_SEQ_FAST_MUL_EN
                        if (w_is_mul) begin
                            r_state  <= S_EXEC;
                            r_mcand  <= req_a;
                            r_mplier <= req_b;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                        end else
`endif
                        begin
                            r_state       <= S_DONE;
                            r_resp_valid  <= 1'b1;
                            r_resp_result <= w_quick_result;
                            r_resp_err    <= w_quick_err;
                        end
                    end
                end
`ifndef ALU_SEQ_FAST_MUL_EN
                S_EXEC: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    // Last multiplier bit folds in this cycle, so DONE lands WIDTH cycles after entering EXEC.
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state       <= S_DONE;
                        r_resp_valid  <= 1'b1;
                        r_resp_result <= w_acc_next;
                        r_resp_err    <= 1'b0;
                    end
                end
`endif
                S_DONE: begin
                    if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign busy        = r_busy;
    assign resp_valid  = r_resp_valid;
    assign resp_result = r_resp_result;
    assign resp_err    = r_resp_err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a transaction-level reference model checked every cycle, plus literal expectations per vector.
module tb_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic [3:0]   req_op = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [W-1:0] resp_result;
    logic         resp_err;
    logic         busy;

    int n_chk  = 0;
    int n_pass = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_result(resp_result),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

`ifdef ALU_SEQ_FAST_MUL_EN
    localparam int MUL_WAIT = 0;
    localparam int MUL_LAT  = 1;
`else
    localparam int MUL_WAIT = W;
    localparam int MUL_LAT  = W + 1;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference arithmetic from the opcode table, in plain wide integer math.
    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
        logic [63:0]  p;
        logic [W-1:0] r;
        logic         e;
        e = 1'b0;
        case (op)
            4'd0: p = 64'(a) + 64'(b);
            4'd1: p = 64'(a) - 64'(b);
            4'd2: p = 64'(a) * 64'(b);
            4'd3: p = (64'(b) >= 64'(W)) ? 64'd0 : (64'(a) << b);
            4'd4: p = (64'(b) >= 64'(W)) ? 64'd0 : (64'(a) >> b);
            default: begin p = 64'd0; e = 1'b1; end
        endcase
        r = p[W-1:0];
        return {e, r};
    endfunction

    // Model: a pending response appears after a latency countdown and stays until taken.
    logic         m_ready, m_valid, m_err, m_busy, m_pend_err;
    logic [W-1:0] m_res, m_pend_res;
    int           m_wait;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready <= 1'b1; m_valid <= 1'b0; m_res <= '0; m_err <= 1'b0;
            m_busy <= 1'b0; m_wait <= 0; m_pend_res <= '0; m_pend_err <= 1'b0;
        end else if (m_ready && req_valid) begin
            logic [W:0] r;
            r = ref_op(req_a, req_b, req_op);
            m_ready <= 1'b0;
            m_busy  <= 1'b1;
            if (req_op == 4'd2 && MUL_WAIT > 0) begin
                m_wait <= MUL_WAIT; m_pend_res <= r[W-1:0]; m_pend_err <= r[W];
            end else begin
                m_valid <= 1'b1; m_res <= r[W-1:0]; m_err <= r[W];
            end
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_valid <= 1'b1; m_res <= m_pend_res; m_err <= m_pend_err;
            end
        end else if (m_valid && resp_ready) begin
            m_valid <= 1'b0; m_ready <= 1'b1; m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("cyc_req_ready",  req_ready,   m_ready);
        chk("cyc_busy",       busy,        m_busy);
        chk("cyc_resp_valid", resp_valid,  m_valid);
        chk("cyc_resp_result", resp_result, m_res);
        chk("cyc_resp_err",   resp_err,    m_err);
    end

    // Drives one op; keeps junk requests on the bus while busy to show they are ignored.
    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] op, input logic [W-1:0] exp_res, input logic exp_err,
                          input int exp_lat, input int hold, input bit rr_early);
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_a = a; req_b = b; req_op = op; resp_ready = rr_early;
        @(negedge clk);
        req_a = $urandom; req_b = $urandom; req_op = 4'($urandom);
        lat = 1;
        while (!resp_valid && lat < 100) begin
            if (lat == 2) begin
                chk({nm, "_busy_mid"}, busy, 1'b1);
                chk({nm, "_rdy_mid"}, req_ready, 1'b0);
            end
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_res"}, resp_result, exp_res);
        chk({nm, "_err"}, resp_err, exp_err);
        if (rr_early) begin
            req_valid = 1'b0;
            @(negedge clk);
            chk({nm, "_one_cycle"}, resp_valid, 1'b0);
            resp_ready = 1'b0;
        end else begin
            repeat (hold) @(negedge clk);
            chk({nm, "_hold_valid"}, resp_valid, 1'b1);
            chk({nm, "_hold_res"}, resp_result, exp_res);
            chk({nm, "_hold_rdy"}, req_ready, 1'b0);
            resp_ready = 1'b1;
            req_valid  = 1'b0;
            @(negedge clk);
            resp_ready = 1'b0;
            chk({nm, "_rdy_back"}, req_ready, 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_valid", resp_valid, 1'b0);
        chk("rst_result", resp_result, '0);
        chk("rst_err", resp_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        #2 rst = 1'b0;

        run_op("add_10_20",  32'd10,         32'd20,   4'b0000, 32'd30,         1'b0, 1, 0, 1'b0);
        run_op("add_wrap",   32'hFFFF_FFFF,  32'd1,    4'b0000, 32'd0,          1'b0, 1, 2, 1'b0);
        run_op("sub_neg",    32'd20,         32'd50,   4'b0001, 32'hFFFF_FFE2,  1'b0, 1, 0, 1'b1);
        run_op("lsh_255_4",  32'd255,        32'd4,    4'b0011, 32'd4080,       1'b0, 1, 1, 1'b0);
        run_op("rsh_1024",   32'd1024,       32'd10,   4'b0100, 32'd1,          1'b0, 1, 0, 1'b0);
        run_op("lsh_oob",    32'd1,          32'd32,   4'b0011, 32'd0,          1'b0, 1, 0, 1'b0);
        run_op("lsh_31",     32'd1,          32'd31,   4'b0011, 32'h8000_0000,  1'b0, 1, 0, 1'b1);
        run_op("rsh_big",    32'hFFFF_FFFF,  32'h100,  4'b0100, 32'd0,          1'b0, 1, 0, 1'b0);
        run_op("mul_1234",   32'd1234,       32'd4321, 4'b0010, 32'd5332114,    1'b0, MUL_LAT, 1, 1'b0);
        run_op("mul_max",    32'hFFFF_FFFF,  32'hFFFF_FFFF, 4'b0010, 32'd1,     1'b0, MUL_LAT, 0, 1'b1);
        run_op("inv_1111",   32'd42,         32'd24,   4'b1111, 32'd0,          1'b1, 1, 5, 1'b0);
        run_op("inv_0101",   32'd7,          32'd9,    4'b0101, 32'd0,          1'b1, 1, 0, 1'b0);
        run_op("add_clr_err", 32'd3,         32'd4,    4'b0000, 32'd7,          1'b0, 1, 0, 1'b0);

        // Abort a 7*8 multiply mid-flight with reset.
        @(negedge clk);
        req_valid = 1'b1; req_a = 32'd7; req_b = 32'd8; req_op = 4'b0010;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_valid", resp_valid, 1'b0);
        chk("abort_result", resp_result, '0);
        chk("abort_err", resp_err, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", req_ready, 1'b1);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_stale", resp_valid, 1'b0);
        run_op("add_1_1", 32'd1, 32'd1, 4'b0000, 32'd2, 1'b0, 1, 0, 1'b0);
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
